// File: rtl/spi_mem_master.sv
// SPI mode-0 master for a serial memory: one command/24-bit-address/data frame per request.
// Build option SPI_FAST_READ_EN switches reads to the 0x0B fast-read frame with one dummy byte.
module spi_mem_master #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_we,
   input  logic                  req_re,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  spi_sck,
   output logic                  spi_cs_n,
   output logic                  spi_mosi,
   input  logic                  spi_miso
);

   localparam int unsigned CNT_W   = 9;
   localparam int unsigned BIT_W   = 6;
   localparam int unsigned FRAME_W = 48;

   localparam logic [7:0]       CMD_WRITE  = 8'h02;
   localparam logic [BIT_W-1:0] WRITE_BITS = 6'd40;
`ifdef SPI_FAST_READ_EN
   localparam logic [7:0]       CMD_READ   = 8'h0B;
   localparam logic [BIT_W-1:0] READ_BITS  = 6'd48;
`else
   localparam logic [7:0]       CMD_READ   = 8'h03;
   localparam logic [BIT_W-1:0] READ_BITS  = 6'd40;
`endif

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
   logic [BIT_W-1:0]     frame_bits, frame_bits_d;
   logic                 is_read, is_read_d;
   logic [FRAME_W-1:0]   shreg, shreg_d;
   logic [7:0]           rx, rx_d;
   logic                 sck_d, cs_n_d, busy_d, done_d;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic [23:0]          addr24;
   logic [FRAME_W-1:0]   wr_frame, rd_frame;

   // Frames are left-aligned so the unused tail of a 40-bit frame shifts out as zeros.
   always_comb begin
      addr24   = 24'(req_addr);
      wr_frame = {CMD_WRITE, addr24, 8'(req_wdata), 8'h00};
      rd_frame = {CMD_READ, addr24, 16'h0000};
   end

   assign spi_mosi = shreg[FRAME_W-1];

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      bit_cnt_d    = bit_cnt;
      frame_bits_d = frame_bits;
      is_read_d    = is_read;
      shreg_d      = shreg;
      rx_d         = rx;
      sck_d        = spi_sck;
      cs_n_d       = spi_cs_n;
      busy_d       = busy;
      done_d       = 1'b0;
      rdata_d      = rdata;

      case (state)
         IDLE: begin
            // Write wins when both request strobes are raised together.
            if (req_we || req_re) begin
               state_d      = CS_SETUP;
               cnt_d        = '0;
               bit_cnt_d    = '0;
               cs_n_d       = 1'b0;
               busy_d       = 1'b1;
               is_read_d    = !req_we;
               shreg_d      = req_we ? wr_frame : rd_frame;
               frame_bits_d = req_we ? WRITE_BITS : READ_BITS;
            end
         end

         CS_SETUP: begin
            if (cnt == HALF_LAST) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end

         SHIFT: begin
            if (cnt == HALF_LAST) begin
               sck_d = 1'b1;
               rx_d  = {rx[6:0], spi_miso};
               cnt_d = cnt + CNT_W'(1);
            end else if (cnt == FULL_LAST) begin
               sck_d   = 1'b0;
               cnt_d   = '0;
               shreg_d = {shreg[FRAME_W-2:0], 1'b0};
               if (bit_cnt == frame_bits - BIT_W'(1)) begin
                  state_d   = CS_HOLD;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end

         CS_HOLD: begin
            if (cnt == HALF_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (is_read) begin
                  rdata_d = DATA_WIDTH'(rx);
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         frame_bits <= '0;
         is_read    <= 1'b0;
         shreg      <= '0;
         rx         <= '0;
         spi_sck    <= 1'b0;
         spi_cs_n   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         rdata      <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         bit_cnt    <= bit_cnt_d;
         frame_bits <= frame_bits_d;
         is_read    <= is_read_d;
         shreg      <= shreg_d;
         rx         <= rx_d;
         spi_sck    <= sck_d;
         spi_cs_n   <= cs_n_d;
         busy       <= busy_d;
         done       <= done_d;
         rdata      <= rdata_d;
      end
   end

endmodule

// File: tb/tb_spi_mem_master.sv
// Randomized self-checking bench for spi_mem_master against a frame-level SPI memory model.
module tb_spi_mem_master;

`ifdef SPI_FAST_READ_EN
   localparam int unsigned CLK_DIV = 1;
   localparam int RD_BITS = 48;
`else
   localparam int unsigned CLK_DIV = 4;
   localparam int RD_BITS = 40;
`endif
   localparam int WR_BITS = 40;

   logic        clk;
   logic        reset;
   logic        req_we;
   logic        req_re;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;
   logic [7:0]  rdata;
   logic        busy;
   logic        done;
   logic        spi_sck;
   logic        spi_cs_n;
   logic        spi_mosi;
   logic        spi_miso;

   spi_mem_master #(
      .CLK_DIV   (CLK_DIV),
      .ADDR_WIDTH(20),
      .DATA_WIDTH(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_we   (req_we),
      .req_re   (req_re),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .spi_sck  (spi_sck),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [47:0] miso_word;
   int          flen;
   int          rise_cnt;
   logic [47:0] cap;
   int          cs_falls;
   int          done_cnt;
   int          mosi_viol;
   logic        prev_mosi;
   logic [7:0]  model_rdata;
   logic        miso_b;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory side: present frame bit k of miso_word while the k-th SCK rise is pending.
   always_comb begin
      miso_b = 1'b0;
      for (int k = 0; k < 48; k++) begin
         if (rise_cnt < flen && k == flen - 1 - rise_cnt) miso_b = miso_word[k];
      end
   end
   assign spi_miso = miso_b;

   initial begin
      rise_cnt = 0;
      cap      = '0;
      cs_falls = 0;
   end

   always @(negedge spi_cs_n or posedge spi_sck) begin
      if (spi_sck) begin
         cap = {cap[46:0], spi_mosi};
         rise_cnt++;
      end else begin
         rise_cnt = 0;
         cap      = '0;
         cs_falls++;
      end
   end

   initial done_cnt = 0;
   always @(negedge clk) if (done === 1'b1) done_cnt++;

   initial begin
      mosi_viol = 0;
      prev_mosi = 1'b0;
   end
   always @(posedge clk) begin
      #1;
      if (spi_mosi !== prev_mosi && spi_sck === 1'b1) mosi_viol++;
      prev_mosi = spi_mosi;
   end

   function automatic logic [47:0] exp_frame(input logic wr, input logic [19:0] addr,
                                             input logic [7:0] wdata);
      logic [23:0] a24;
      a24 = 24'(addr);
      if (wr) return 48'({8'h02, a24, wdata});
`ifdef SPI_FAST_READ_EN
      return {8'h0B, a24, 16'h0000};
`else
      return 48'({8'h03, a24, 8'h00});
`endif
   endfunction

   task automatic run_txn(input logic we, input logic re, input logic [19:0] addr,
                          input logic [7:0] wdata, input logic [7:0] mbyte, input int inj);
      int          cyc;
      int          exp_cyc;
      int          bits;
      int          d0;
      int          c0;
      logic [47:0] ef;
      bits    = we ? WR_BITS : RD_BITS;
      ef      = exp_frame(we, addr, wdata);
      exp_cyc = 2 * CLK_DIV * bits + 2 * CLK_DIV;
      @(negedge clk);
      miso_word = {16'($urandom), 24'($urandom), mbyte};
      flen      = bits;
      d0        = done_cnt;
      c0        = cs_falls;
      req_we    = we;
      req_re    = re;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_we = 1'b0;
      req_re = 1'b0;
      check("accept_cs_n", 64'(spi_cs_n), 64'd0);
      check("accept_busy", 64'(busy), 64'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < exp_cyc + 20) begin
         @(negedge clk);
         req_re = (inj > 0 && cyc == inj);
         @(posedge clk);
         #1;
         cyc++;
      end
      req_re = 1'b0;
      if (!we) model_rdata = mbyte;
      check("done_latency", 64'(cyc), 64'(exp_cyc));
      check("mosi_frame", 64'(cap), 64'(ef));
      check("sck_rises", 64'(rise_cnt), 64'(bits));
      check("done_cs_n", 64'(spi_cs_n), 64'd1);
      check("done_busy", 64'(busy), 64'd0);
      check("rdata", 64'(rdata), 64'(model_rdata));
      @(posedge clk);
      #1;
      check("done_width", 64'(done), 64'd0);
      check("done_count", 64'(done_cnt - d0), 64'd1);
      check("frame_count", 64'(cs_falls - c0), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      int          d0;
      logic        we;
      logic        re;
      reset       = 1'b1;
      req_we      = 1'b0;
      req_re      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      miso_word   = '0;
      flen        = 0;
      model_rdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", 64'(spi_cs_n), 64'd1);
      check("rst_sck", 64'(spi_sck), 64'd0);
      check("rst_mosi", 64'(spi_mosi), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_txn(1'b1, 1'b0, 20'h00100, 8'h55, 8'h00, 0);
      run_txn(1'b0, 1'b1, 20'h00100, 8'h00, 8'hAA, 0);
      run_txn(1'b1, 1'b1, 20'h00010, 8'h3C, 8'h5A, 0);
      run_txn(1'b1, 1'b0, 20'h00200, 8'h81, 8'h00, 20);

      // Abort a read part-way through the address bits.
      @(negedge clk);
      miso_word = {40'h0, 8'hAA};
      flen      = RD_BITS;
      req_re    = 1'b1;
      req_addr  = 20'h00100;
      @(posedge clk);
      #1;
      req_re = 1'b0;
      d0  = done_cnt;
      cyc = 0;
      while (rise_cnt < 12 && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("reach_bit12", 64'(rise_cnt), 64'd12);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      model_rdata = 8'h00;
      check("abort_cs_n", 64'(spi_cs_n), 64'd1);
      check("abort_sck", 64'(spi_sck), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_rdata", 64'(rdata), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      run_txn(1'b0, 1'b1, 20'h00100, 8'h00, 8'hAA, 0);

      for (int i = 0; i < 8; i++) begin
         we = 1'($urandom);
         re = we ? 1'($urandom) : 1'b1;
         run_txn(we, re, 20'($urandom), 8'($urandom), 8'($urandom), 0);
      end

      check("mosi_only_sck_low", 64'(mosi_viol), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
